// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin: one shared full-subtractor cell walks the operands
// LSB first over WIDTH cycles, with valid/ready handshakes on both sides.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             d_bit;
    logic             bo_bit;
    logic             accept;

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bw);
        sub_cell = {(~x & y) | (y & bw) | (~x & bw), x ^ y ^ bw};
    endfunction

    always_comb begin
        {bo_bit, d_bit} = sub_cell(sa[0], sb[0], br);
        sr_next = WIDTH'({d_bit, diff_sr} >> 1);
        accept  = in_ready & in_valid;
    end

    // Operand and partial-result shifters carry no reset: they are always
    // fully reloaded or fully shifted through before their contents are used.
    always_ff @(posedge clk) begin
        if (accept) begin
            sa <= a;
            sb <= b;
        end else if (state == RUN) begin
            sa      <= sa >> 1;
            sb      <= sb >> 1;
            diff_sr <= sr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        br       <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    br  <= bo_bit;
                    cnt <= cnt + 1'b1;
                    // Final bit: publish the whole word at once so diff never shows partials.
                    if (cnt == LAST) begin
                        diff      <= sr_next;
                        bout      <= bo_bit;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: an 8-bit and a 1-bit instance, each
// checked against plain-arithmetic subtraction.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, bin8, bout8, busy8;
    logic [7:0] a8, b8, diff8;
    logic       iv1, ir1, ov1, or1, bin1, bout1, busy1;
    logic [0:0] a1, b1, diff1;

    typedef struct {
        int d;
        int bo;
        int acc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   t4_mode = 1'b0;
    int   t4_n = 0;
    int   last_hs = 0;

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8),
        .diff(diff8), .bout(bout8), .busy(busy8)
    );

    serial_sub_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(or1),
        .diff(diff1), .bout(bout1), .busy(busy1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: integer subtraction, wrapped to w bits; negative means borrow out.
    function automatic exp_t ref_sub(input int a, input int b, input int bin, input int w,
                                     input int acc);
        exp_t e;
        int   r;
        r     = a - b - bin;
        e.d   = (r + (1 << w)) % (1 << w);
        e.bo  = (r < 0) ? 1 : 0;
        e.acc = acc;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor for the 8-bit instance.
    initial begin
        exp_t e;
        logic pov;
        pov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ov8 && !pov) begin
                    chk("u8_result_expected", int'(q8.size() > 0), 1);
                    if (q8.size() > 0) chk("u8_latency", cyc - q8[0].acc, 8);
                end
                if (ov8 && or8 && q8.size() > 0) begin
                    e = q8.pop_front();
                    chk("u8_diff", int'(diff8), e.d);
                    chk("u8_bout", int'(bout8), e.bo);
                    if (t4_mode) begin
                        if (t4_n > 0) chk("u8_issue_gap", cyc - last_hs, 10);
                        t4_n++;
                    end
                    last_hs = cyc;
                end
                if (iv8 && ir8)
                    q8.push_back(ref_sub(int'(a8), int'(b8), int'(bin8), 8, cyc + 1));
            end
            pov = ov8;
        end
    end

    // Monitor for the 1-bit instance.
    initial begin
        exp_t e;
        logic pov;
        pov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ov1 && !pov) begin
                    chk("u1_result_expected", int'(q1.size() > 0), 1);
                    if (q1.size() > 0) chk("u1_latency", cyc - q1[0].acc, 1);
                end
                if (ov1 && or1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("u1_diff", int'(diff1), e.d);
                    chk("u1_bout", int'(bout1), e.bo);
                end
                if (iv1 && ir1)
                    q1.push_back(ref_sub(int'(a1), int'(b1), int'(bin1), 1, cyc + 1));
            end
            pov = ov1;
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bn,
                         output int waited);
        iv8 = 1'b1; a8 = a; b8 = b; bin8 = bn;
        waited = -1;
        for (int i = 0; i < 200; i++) begin
            if (ir8) begin
                waited = i;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        chk("u8_accepted", int'(waited >= 0), 1);
    endtask

    task automatic send1(input logic a, input logic b, input logic bn);
        int waited;
        iv1 = 1'b1; a1 = a; b1 = b; bin1 = bn;
        waited = -1;
        for (int i = 0; i < 50; i++) begin
            if (ir1) begin
                waited = i;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        iv1 = 1'b0;
        chk("u1_accepted", int'(waited >= 0), 1);
    endtask

    task automatic wait_ov8();
        for (int i = 0; i < 50 && !ov8; i++) begin
            @(posedge clk); #1;
        end
        chk("u8_out_valid_seen", int'(ov8), 1);
    endtask

    task automatic drain8();
        for (int i = 0; i < 100 && (q8.size() > 0 || ov8); i++) begin
            @(posedge clk); #1;
        end
        chk("u8_drained", q8.size(), 0);
    endtask

    task automatic drain1();
        for (int i = 0; i < 20 && (q1.size() > 0 || ov1); i++) begin
            @(posedge clk); #1;
        end
        chk("u1_drained", q1.size(), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w;
        exp_t e;
        logic [7:0] ra, rb;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; bin8 = 1'b0;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; bin1 = 1'b0;

        #12;
        chk("rst_in_ready", int'(ir8), 1);
        chk("rst_out_valid", int'(ov8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_diff", int'(diff8), 0);
        chk("rst_bout", int'(bout8), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 / T2
        send8(8'h5A, 8'h3C, 1'b0, w);
        drain8();
        send8(8'h00, 8'h01, 1'b0, w);
        drain8();
        send8(8'h10, 8'h10, 1'b1, w);
        drain8();

        // T3: back-pressure in DONE
        or8 = 1'b0;
        send8(8'hC3, 8'h4D, 1'b1, w);
        chk("t3_busy_run", int'(busy8), 1);
        wait_ov8();
        e = ref_sub(8'hC3, 8'h4D, 1, 8, 0);
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            chk("t3_hold_diff", int'(diff8), e.d);
            chk("t3_hold_bout", int'(bout8), e.bo);
            chk("t3_hold_valid", int'(ov8), 1);
            chk("t3_in_ready_low", int'(ir8), 0);
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("t3_valid_fell", int'(ov8), 0);
        chk("t3_in_ready_back", int'(ir8), 1);
        chk("t3_busy_idle", int'(busy8), 0);
        send8(8'h81, 8'hF0, 1'b0, w);
        chk("t3_next_accept_wait", w, 0);
        drain8();

        // T4: back-to-back with out_ready held high
        t4_mode = 1'b1; t4_n = 0;
        for (int i = 0; i < 4; i++) send8(8'($urandom), 8'($urandom), 1'($urandom), w);
        drain8();
        t4_mode = 1'b0;
        chk("t4_results", t4_n, 4);

        // Random operands, including extremes, with random back-pressure
        for (int i = 0; i < 12; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 4) == 0) ra = 8'h00;
            or8 = 1'b0;
            send8(ra, rb, 1'($urandom), w);
            wait_ov8();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            or8 = 1'b1;
            drain8();
        end

        // T5: async reset in the middle of RUN
        send8(8'h77, 8'h22, 1'b0, w);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", int'(ov8), 0);
        chk("t5_in_ready", int'(ir8), 1);
        chk("t5_diff", int'(diff8), 0);
        chk("t5_bout", int'(bout8), 0);
        chk("t5_busy", int'(busy8), 0);
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("t5_no_stale_result", int'(ov8), 0);
        send8(8'h01, 8'h02, 1'b0, w);
        drain8();

        // T6: WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            send1(1'(i >> 2), 1'(i >> 1), 1'(i));
            drain1();
        end

        chk("final_q8_empty", q8.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
